// File: rtl/tb_mem_regbus.sv
// Word-addressed regbus memory model: one access per transaction, registered
// response one cycle after accept, error on accesses outside the window.
module tb_mem_regbus #(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 32,
    parameter int NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [DataWidth-1:0]   reg_wdata_i,
    input  logic [DataWidth/8-1:0] reg_wstrb_i,
    output logic                   reg_ready_o,
    output logic [DataWidth-1:0]   reg_rdata_o,
    output logic                   reg_error_o
);

    localparam int StrbW = DataWidth / 8;
    localparam int BW    = $clog2(StrbW);
    localparam int IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [AddrWidth-1:0] Depth = AddrWidth'(NumWords);

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state;
    logic [DataWidth-1:0] mem [NumWords];
    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] idx;
    logic [IdxW-1:0]      widx;
    logic                 in_range;

    // idx is compared at full width so addresses past the window never alias
    assign off      = reg_addr_i - BaseAddr;
    assign idx      = off >> BW;
    assign widx     = idx[IdxW-1:0];
    assign in_range = (reg_addr_i >= BaseAddr) && (idx < Depth);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            reg_ready_o <= 1'b0;
            reg_rdata_o <= '0;
            reg_error_o <= 1'b0;
            for (int i = 0; i < NumWords; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_valid_i) begin
                        state       <= RESP;
                        reg_ready_o <= 1'b1;
                        reg_error_o <= !in_range;
                        reg_rdata_o <= (in_range && !reg_write_i) ? mem[widx] : '0;
                        // write lands at the accept edge, so a following read sees it
                        if (in_range && reg_write_i) begin
                            for (int b = 0; b < StrbW; b++) begin
                                if (reg_wstrb_i[b]) mem[widx][8*b +: 8] <= reg_wdata_i[8*b +: 8];
                            end
                        end
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    reg_ready_o <= 1'b0;
                    reg_rdata_o <= '0;
                    reg_error_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_mem_regbus.sv
// Directed bench for tb_mem_regbus: two instances (base 0 and base 0x1000_0000)
// checked every cycle against a transaction-level model plus literal expectations.
module tb_tb_mem_regbus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  vld = 2'b00;
    logic        wr_s = 1'b0;
    logic [47:0] addr_s = '0;
    logic [31:0] wdata_s = '0;
    logic [3:0]  wstrb_s = '0;

    logic        ready0, ready1, err0, err1;
    logic [31:0] rdata0, rdata1;

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    tb_mem_regbus #(.AddrWidth(48), .DataWidth(32), .NumWords(1024), .BaseAddr(48'h0)) dut0 (
        .clk_i(clk), .rst_i(rst), .reg_valid_i(vld[0]), .reg_write_i(wr_s),
        .reg_addr_i(addr_s), .reg_wdata_i(wdata_s), .reg_wstrb_i(wstrb_s),
        .reg_ready_o(ready0), .reg_rdata_o(rdata0), .reg_error_o(err0)
    );

    tb_mem_regbus #(.AddrWidth(48), .DataWidth(32), .NumWords(1024), .BaseAddr(48'h1000_0000)) dut1 (
        .clk_i(clk), .rst_i(rst), .reg_valid_i(vld[1]), .reg_write_i(wr_s),
        .reg_addr_i(addr_s), .reg_wdata_i(wdata_s), .reg_wstrb_i(wstrb_s),
        .reg_ready_o(ready1), .reg_rdata_o(rdata1), .reg_error_o(err1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model: a 4 KiB window starting at the instance base, byte-lane merge on write.
    logic [31:0] mm [2][1024];
    bit   [1:0]  exp_rdy;
    logic [31:0] exp_rd [2];
    bit   [1:0]  exp_er;

    function automatic longint unsigned base_of(int k);
        return (k == 1) ? 64'h1000_0000 : 64'h0;
    endfunction

    function automatic bit hit(int k, logic [47:0] a);
        longint unsigned aa = {16'h0, a};
        return (aa >= base_of(k)) && (aa - base_of(k) < 4096);
    endfunction

    function automatic int word_of(int k, logic [47:0] a);
        longint unsigned aa = {16'h0, a};
        return int'((aa - base_of(k)) / 4);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int w = 0; w < 1024; w++) mm[k][w] <= '0;
                exp_rdy[k] <= 1'b0;
                exp_rd[k]  <= '0;
                exp_er[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (exp_rdy[k]) begin
                    exp_rdy[k] <= 1'b0;
                    exp_rd[k]  <= '0;
                    exp_er[k]  <= 1'b0;
                end else if (vld[k]) begin
                    exp_rdy[k] <= 1'b1;
                    if (!hit(k, addr_s)) begin
                        exp_er[k] <= 1'b1;
                        exp_rd[k] <= '0;
                    end else begin
                        exp_er[k] <= 1'b0;
                        exp_rd[k] <= wr_s ? 32'h0 : mm[k][word_of(k, addr_s)];
                        if (wr_s) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wstrb_s[b]) mm[k][word_of(k, addr_s)][8*b +: 8] <= wdata_s[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc ready0", {31'h0, ready0}, {31'h0, exp_rdy[0]});
            check("cyc rdata0", rdata0, exp_rd[0]);
            check("cyc error0", {31'h0, err0}, {31'h0, exp_er[0]});
            check("cyc ready1", {31'h0, ready1}, {31'h0, exp_rdy[1]});
            check("cyc rdata1", rdata1, exp_rd[1]);
            check("cyc error1", {31'h0, err1}, {31'h0, exp_er[1]});
        end
    end

    // Called just after a rising edge with the target idle; returns what the
    // DUT shows in the cycle after the accept edge.
    task automatic xfer(input int k, input bit wr, input logic [47:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output logic er, output logic rdy);
        wr_s = wr; addr_s = a; wdata_s = wd; wstrb_s = ws;
        vld[k] = 1'b1;
        @(posedge clk); #1;
        vld = 2'b00;
        @(negedge clk);
        rdy = (k == 1) ? ready1 : ready0;
        rd  = (k == 1) ? rdata1 : rdata0;
        er  = (k == 1) ? err1 : err0;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string nm, input int k, input logic [47:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic e, r;
        xfer(k, 1'b0, a, 32'h0, 4'hF, d, e, r);
        check({nm, " ready"}, {31'h0, r}, 32'h1);
        check({nm, " rdata"}, d, exp_d);
        check({nm, " error"}, {31'h0, e}, {31'h0, exp_e});
    endtask

    task automatic wr_chk(input string nm, input int k, input logic [47:0] a,
                          input logic [31:0] wd, input logic [3:0] ws, input logic exp_e);
        logic [31:0] d;
        logic e, r;
        xfer(k, 1'b1, a, wd, ws, d, e, r);
        check({nm, " ready"}, {31'h0, r}, 32'h1);
        check({nm, " rdata"}, d, 32'h0);
        check({nm, " error"}, {31'h0, e}, {31'h0, exp_e});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic [9:0] pat;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset ready0", {31'h0, ready0}, 32'h0);
        check("reset rdata0", rdata0, 32'h0);
        check("reset error0", {31'h0, err0}, 32'h0);
        @(posedge clk); #1;

        rd_chk("rd 0x0 after reset", 0, 48'h0, 32'h0, 1'b0);
        rd_chk("rd 0xFFC after reset", 0, 48'hFFC, 32'h0, 1'b0);

        wr_chk("wr 0x10 full", 0, 48'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        rd_chk("rd 0x10 full", 0, 48'h10, 32'hDEADBEEF, 1'b0);
        wr_chk("wr 0x10 strb 0101", 0, 48'h10, 32'h11223344, 4'b0101, 1'b0);
        rd_chk("rd 0x10 merged", 0, 48'h10, 32'hDE22BE44, 1'b0);
        rd_chk("rd 0x13 misaligned", 0, 48'h13, 32'hDE22BE44, 1'b0);
        wr_chk("wr 0x10 no strobes", 0, 48'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
        rd_chk("rd 0x10 after empty wr", 0, 48'h10, 32'hDE22BE44, 1'b0);

        rd_chk("rd 0x1000 oor", 0, 48'h1000, 32'h0, 1'b1);
        wr_chk("wr 0x1000 oor", 0, 48'h1000, 32'hA5A5A5A5, 4'hF, 1'b1);
        rd_chk("rd 0x0 no alias", 0, 48'h0, 32'h0, 1'b0);
        rd_chk("rd top of 48b space", 0, 48'hFFFF_FFFF_FFFC, 32'h0, 1'b1);

        rd_chk("base1 rd below", 1, 48'h0FFF_FFFC, 32'h0, 1'b1);
        rd_chk("base1 rd word0", 1, 48'h1000_0000, 32'h0, 1'b0);
        wr_chk("base1 wr last word", 1, 48'h1000_0FFC, 32'hCAFEF00D, 4'hF, 1'b0);
        rd_chk("base1 rd last word", 1, 48'h1000_0FFC, 32'hCAFEF00D, 1'b0);
        rd_chk("base1 rd past end", 1, 48'h1000_1000, 32'h0, 1'b1);
        rd_chk("base0 rd 0xFFC untouched", 0, 48'hFFC, 32'h0, 1'b0);

        // valid held for 10 edges: one accept every other cycle
        pulses = 0;
        pat = '0;
        wr_s = 1'b0; addr_s = 48'h10; wstrb_s = 4'hF;
        vld[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 9) vld[0] = 1'b0;
            @(negedge clk);
            if (ready0) begin
                pulses++;
                pat[i] = 1'b1;
            end
        end
        @(posedge clk); #1;
        check("held valid pulses", pulses, 32'd5);
        check("held valid pattern", {22'h0, pat}, {22'h0, 10'b0101010101});

        // reset lands in the response cycle of a write
        wr_s = 1'b1; addr_s = 48'h20; wdata_s = 32'h12345678; wstrb_s = 4'hF;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset drop", {31'h0, ready0}, 32'h0);
        @(negedge clk);
        check("no late ready", {31'h0, ready0}, 32'h0);
        @(posedge clk); #1;
        rd_chk("rd 0x20 after reset", 0, 48'h20, 32'h0, 1'b0);
        rd_chk("rd 0x10 after reset", 0, 48'h10, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
